// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory arbiter and its latency counter.
package cpu_mem_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} mem_owner_t;

  localparam int MAX_MEM_LAT = 7;
  localparam int LAT_CNT_W   = $clog2(MAX_MEM_LAT + 1);

endpackage

// File: rtl/mem_lat_counter.sv
// Fixed-latency tracker: loads to 1 on an issue, counts up, flags done at LAT.
module mem_lat_counter
  import cpu_mem_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_C = LAT_CNT_W'(LAT);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  // A reload in the done cycle restarts the count for back-to-back accesses.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LAT_CNT_W'(1);
    end else if (cnt_q == LAT_C) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + LAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// the load/store path; one access outstanding, fixed read latency.
//
//   state    | meaning
//   ARB_IDLE | no access outstanding, grant may issue
//   ARB_BUSY | access outstanding for owner_q; completes when the counter hits MEM_LAT
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LAT     = 2,
  parameter int DATA_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              f_flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);

  arb_state_t           state_q, state_d;
  mem_owner_t           owner_q, owner_d;
  logic                 kill_q, kill_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;

  logic lat_done;
  logic cmpl;
  logic can_grant;
  logic fetch_win;
  logic f_win_gnt;
  logic d_win_gnt;

  assign cmpl      = (state_q == ARB_BUSY) && lat_done;
  assign can_grant = !reset && ((state_q == ARB_IDLE) || cmpl);
  // Fetch only overtakes a waiting data request once the streak limit is hit.
  assign fetch_win = f_req && (!d_req || (streak_q == STREAK_MAX));
  assign f_win_gnt = can_grant && fetch_win;
  assign d_win_gnt = can_grant && d_req && !fetch_win;

  mem_lat_counter #(
    .LAT(MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .reset (reset),
    .load_i(f_win_gnt || d_win_gnt),
    .done_o(lat_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      kill_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      kill_q   <= kill_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    kill_d   = kill_q;
    streak_d = streak_q;
    if (cmpl) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
      kill_d  = 1'b0;
    end else if ((state_q == ARB_BUSY) && (owner_q == OWN_FETCH) && f_flush) begin
      kill_d = 1'b1;
    end
    if (f_win_gnt) begin
      state_d  = ARB_BUSY;
      owner_d  = OWN_FETCH;
      kill_d   = f_flush;
      streak_d = '0;
    end else if (d_win_gnt) begin
      state_d = ARB_BUSY;
      owner_d = OWN_DATA;
      kill_d  = 1'b0;
      if (!f_req) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_comb begin
    f_gnt     = f_win_gnt;
    d_gnt     = d_win_gnt;
    mem_en    = f_win_gnt || d_win_gnt;
    mem_we    = d_win_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_win_gnt) begin
      mem_addr = f_addr;
    end else if (d_win_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end
    f_valid = cmpl && !reset && (owner_q == OWN_FETCH) && !kill_q && !f_flush;
    d_valid = cmpl && !reset && (owner_q == OWN_DATA);
    f_rdata = f_valid ? mem_rdata : '0;
    d_rdata = d_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Per-cycle vector table for the directed scenarios, then a held-request
// stream checked through a response scoreboard and a small memory model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, f_req, f_flush, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_gnt, f_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .DATA_STREAK(3)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_rdata(f_rdata), .f_flush(f_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // in  = {reset, f_req, f_flush, d_req, d_we}
  // ctl = {f_gnt, d_gnt, f_valid, d_valid, mem_en, mem_we}
  typedef struct {
    string       name;
    logic [4:0]  in;
    logic [15:0] faddr, daddr, dwdata, mrd;
    logic [5:0]  ctl;
    logic [15:0] maddr, mwdata, frd, drd;
  } vec_t;

  typedef struct {
    logic        is_f;
    int          cyc;
    logic [15:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(string nm, logic [4:0] in, logic [15:0] faddr, logic [15:0] daddr,
                              logic [15:0] dwdata, logic [15:0] mrd, logic [5:0] ctl,
                              logic [15:0] maddr, logic [15:0] mwdata, logic [15:0] frd,
                              logic [15:0] drd);
    vec_t v;
    v.name = nm; v.in = in; v.faddr = faddr; v.daddr = daddr; v.dwdata = dwdata;
    v.mrd = mrd; v.ctl = ctl; v.maddr = maddr; v.mwdata = mwdata; v.frd = frd; v.drd = drd;
    return v;
  endfunction

  initial begin
    logic [69:0] act, exp_v;
    logic        en_h[64];
    logic [15:0] addr_h[64];
    logic [15:0] fa, da, ed, ad;
    logic        exp_fv, exp_dv;
    int          g, last_g;

    reset = 1'b1; f_req = 1'b0; f_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    vecs.push_back(mk("rst0",      5'b10000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rst_req",   5'b11010, 16'h0010, 16'h0100, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("f1_gnt",    5'b01000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0010, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("f1_wait",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("f1_valid",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h2005, 6'b001000, 16'h0000, 16'h0000, 16'h2005, 16'h0000));
    vecs.push_back(mk("f1_after",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h2005, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("st_gnt",    5'b00011, 16'h0000, 16'h0040, 16'hBEEF, 16'h0000, 6'b010011, 16'h0040, 16'hBEEF, 16'h0000, 16'h0000));
    vecs.push_back(mk("st_wait",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("st_done",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000100, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("sim_dgnt",  5'b01010, 16'h0020, 16'h0100, 16'h0000, 16'h0000, 6'b010010, 16'h0100, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("sim_wait",  5'b01000, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("sim_fgnt",  5'b01000, 16'h0020, 16'h0000, 16'h0000, 16'h1234, 6'b100110, 16'h0020, 16'h0000, 16'h0000, 16'h1234));
    vecs.push_back(mk("sim_fwait", 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("sim_fval",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h4321, 6'b001000, 16'h0000, 16'h0000, 16'h4321, 16'h0000));
    vecs.push_back(mk("fl_gnt",    5'b01000, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0030, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fl_flush",  5'b00110, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fl_dgnt",   5'b00010, 16'h0000, 16'h0200, 16'h0000, 16'h5555, 6'b010010, 16'h0200, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fl_dwait",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fl_dval",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h6666, 6'b000100, 16'h0000, 16'h0000, 16'h0000, 16'h6666));
    vecs.push_back(mk("flg_gnt",   5'b01100, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0040, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flg_wait",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flg_kill",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h7777, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flc_gnt",   5'b01000, 16'h0058, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0058, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flc_wait",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flc_kill",  5'b00100, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flx_idle",  5'b00100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flx_gnt",   5'b01000, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0050, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flx_wait",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("flx_val",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0A0A, 6'b001000, 16'h0000, 16'h0000, 16'h0A0A, 16'h0000));
    vecs.push_back(mk("fld_gnt",   5'b00010, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 6'b010010, 16'h0300, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fld_flush", 5'b00100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("fld_val",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0B0B, 6'b000100, 16'h0000, 16'h0000, 16'h0000, 16'h0B0B));
    vecs.push_back(mk("rm_gnt",    5'b01000, 16'h0060, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0060, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_rst",    5'b10000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_drop",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0C0C, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_idle",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_dgnt",   5'b00010, 16'h0000, 16'h0070, 16'h0000, 16'h0000, 6'b010010, 16'h0070, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_dwait",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rm_dval",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0D0D, 6'b000100, 16'h0000, 16'h0000, 16'h0000, 16'h0D0D));
    vecs.push_back(mk("rc_gnt",    5'b01000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0080, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rc_wait",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rc_rst",    5'b11000, 16'h0080, 16'h0000, 16'h0000, 16'h0E0E, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rc_regnt",  5'b01000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 6'b100010, 16'h0080, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rc_wait2",  5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("rc_val",    5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 6'b001000, 16'h0000, 16'h0000, 16'h0F0F, 16'h0000));
    vecs.push_back(mk("rc_idle",   5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      {reset, f_req, f_flush, d_req, d_we} = vecs[i].in;
      f_addr = vecs[i].faddr; d_addr = vecs[i].daddr;
      d_wdata = vecs[i].dwdata; mem_rdata = vecs[i].mrd;
      @(negedge clk);
      act   = {f_gnt, d_gnt, f_valid, d_valid, mem_en, mem_we, mem_addr, mem_wdata, f_rdata, d_rdata};
      exp_v = {vecs[i].ctl, vecs[i].maddr, vecs[i].mwdata, vecs[i].frd, vecs[i].drd};
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", vecs[i].name, act, exp_v);
      end
    end

    // Both requesters held: grant order D,D,D,F every MEM_LAT cycles.
    fa = 16'h1000; da = 16'h2000; g = 0; last_g = 0;
    f_flush = 1'b0; d_we = 1'b0; reset = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(posedge clk); #1;
      f_req = (c < 36); d_req = (c < 36);
      f_addr = fa; d_addr = da;
      mem_rdata = 16'h0000;
      if (c >= LAT) begin
        if (en_h[c-LAT]) mem_rdata = addr_h[c-LAT] ^ 16'hA5A5;
      end
      @(negedge clk);
      en_h[c] = mem_en; addr_h[c] = mem_addr;
      if (f_gnt || d_gnt) begin
        n_checks++;
        if ((f_gnt && d_gnt) || (f_gnt != ((g % 4) == 3))) begin
          n_fail++;
          $display("FAIL grant_order: grant %0d f_gnt=%0b d_gnt=%0b required f_gnt=%0b", g, f_gnt, d_gnt, ((g % 4) == 3));
        end
        if (g > 0) begin
          n_checks++;
          if (c - last_g != LAT) begin
            n_fail++;
            $display("FAIL grant_spacing: gap %0d cycles required %0d", c - last_g, LAT);
          end
        end
        if (f_gnt) begin
          sbq.push_back('{is_f: 1'b1, cyc: c + LAT, data: fa ^ 16'hA5A5});
          fa = fa + 16'd1;
        end else begin
          sbq.push_back('{is_f: 1'b0, cyc: c + LAT, data: da ^ 16'hA5A5});
          da = da + 16'd1;
        end
        g++; last_g = c;
      end
      exp_fv = 1'b0; exp_dv = 1'b0; ed = 16'h0000;
      if (sbq.size() > 0) begin
        if (sbq[0].cyc == c) begin
          exp_fv = sbq[0].is_f; exp_dv = !sbq[0].is_f; ed = sbq[0].data;
          void'(sbq.pop_front());
        end
      end
      if (f_valid || d_valid || exp_fv || exp_dv) begin
        ad = f_valid ? f_rdata : d_rdata;
        n_checks++;
        if ({f_valid, d_valid, ad} !== {exp_fv, exp_dv, ed}) begin
          n_fail++;
          $display("FAIL sb_resp: cycle %0d actual fv=%0b dv=%0b data=%h required fv=%0b dv=%0b data=%h",
                   c, f_valid, d_valid, ad, exp_fv, exp_dv, ed);
        end
      end
    end

    n_checks++;
    if (sbq.size() != 0 || g != 18) begin
      n_fail++;
      $display("FAIL sb_drain: pending %0d grants %0d required pending 0 grants 18", sbq.size(), g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
